// File: rtl/phy_seq_cfg.sv
// PHY sequencer: ID read, variant table writes over MDIO, then link/speed/duplex polling.
// One MDIO transaction at a time (issue on ready, BUSY, DONE). Optional watchdog: PHY_SEQ_WATCHDOG_EN.
module phy_seq_cfg #(
  parameter int          IDX_W      = 3,
  parameter int          DEPTH_A    = 4,
  parameter int          DEPTH_B    = 2,
  parameter logic [4:0]  ID_REG     = 5'h03,
  parameter logic [15:0] ID_MASK    = 16'h0030,
  parameter logic [15:0] ID_MATCH   = 16'h0010,
  parameter logic [4:0]  STATUS_REG = 5'h1f,
  parameter int          POLL_GAP   = 250,
  parameter int          TIMEOUT    = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             init_request,
  output logic             tbl_sel,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [4:0]       tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic [4:0]       mdio_addr,
  output logic [15:0]      mdio_wr_data,
  output logic             mdio_rd_request,
  output logic             mdio_wr_request,
  input  logic             mdio_ready,
  input  logic [15:0]      mdio_rd_data,
  output logic [1:0]       speed,
  output logic             duplex,
  output logic             link,
  output logic             phy_variant,
  output logic             cfg_done,
  output logic             status_valid,
  output logic             link_change,
  output logic             err
);

  typedef enum logic [2:0] {S_ID_RD, S_WR, S_POLL_ST, S_POLL_BM, S_GAP} state_e;
  typedef enum logic [1:0] {PH_ISSUE, PH_BUSY, PH_DONE} phase_e;

  localparam int               GAP_W    = $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_A   = IDX_W'(DEPTH_A - 1);
  localparam logic [IDX_W-1:0] LAST_B   = IDX_W'(DEPTH_B - 1);
  localparam logic [4:0]       BMSR_REG = 5'h01;

  state_e           state_q;
  phase_e           phase_q;
  logic [GAP_W-1:0] gap_q;
  logic             pending_q;
  logic             sel_q;
  logic [IDX_W-1:0] idx_q;
  logic [4:0]       addr_q;
  logic [15:0]      wdat_q;
  logic             rd_q, wr_q;
  logic [1:0]       speed_q;
  logic             duplex_q, link_q, var_q, done_q, sv_q, lc_q;

  logic             pend_d, id_b_d;
  logic [IDX_W-1:0] last_idx_d;

  assign pend_d     = pending_q | init_request;
  assign id_b_d     = (mdio_rd_data & ID_MASK) != ID_MATCH;
  assign last_idx_d = sel_q ? LAST_B : LAST_A;

`ifdef PHY_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            reinit_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_ID_RD;
      phase_q   <= PH_ISSUE;
      gap_q     <= '0;
      pending_q <= 1'b0;
      sel_q     <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      speed_q   <= 2'b00;
      duplex_q  <= 1'b0;
      link_q    <= 1'b0;
      var_q     <= 1'b0;
      done_q    <= 1'b0;
      sv_q      <= 1'b0;
      lc_q      <= 1'b0;
`ifdef PHY_SEQ_WATCHDOG_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
      reinit_q  <= 1'b0;
`endif
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      sv_q <= 1'b0;
      lc_q <= 1'b0;
      if (init_request) pending_q <= 1'b1;
`ifdef PHY_SEQ_WATCHDOG_EN
      if (phase_q != PH_ISSUE) wd_q <= wd_q + WD_W'(1);
`endif
      case (phase_q)
        PH_ISSUE: begin
          if (state_q == S_GAP) begin
            if (pend_d) begin
              state_q   <= S_ID_RD;
              pending_q <= 1'b0;
              done_q    <= 1'b0;
`ifdef PHY_SEQ_WATCHDOG_EN
              reinit_q  <= 1'b0;
`endif
            end else if (gap_q == GAP_LAST) begin
              gap_q   <= '0;
`ifdef PHY_SEQ_WATCHDOG_EN
              state_q  <= reinit_q ? S_ID_RD : S_POLL_ST;
              reinit_q <= 1'b0;
`else
              state_q <= S_POLL_ST;
`endif
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end else if (mdio_ready) begin
            phase_q <= PH_BUSY;
`ifdef PHY_SEQ_WATCHDOG_EN
            wd_q    <= '0;
`endif
            case (state_q)
              S_WR:      begin addr_q <= tbl_addr; wdat_q <= tbl_data; wr_q <= 1'b1; end
              S_POLL_ST: begin addr_q <= STATUS_REG; rd_q <= 1'b1; end
              S_POLL_BM: begin addr_q <= BMSR_REG; rd_q <= 1'b1; end
              default:   begin addr_q <= ID_REG; rd_q <= 1'b1; end
            endcase
          end
        end
        // Ready may still be high from before the strobe; only a low level proves the engine took it.
        PH_BUSY: if (!mdio_ready) phase_q <= PH_DONE;
        PH_DONE: begin
          if (mdio_ready) begin
            phase_q <= PH_ISSUE;
            case (state_q)
              S_ID_RD: begin
                var_q   <= id_b_d;
                sel_q   <= id_b_d;
                idx_q   <= '0;
                done_q  <= 1'b0;
                state_q <= S_WR;
              end
              S_WR: begin
                if (idx_q == last_idx_d) begin
                  done_q  <= 1'b1;
                  state_q <= S_POLL_ST;
                end else begin
                  idx_q <= idx_q + IDX_W'(1);
                end
              end
              S_POLL_ST: begin
                speed_q  <= mdio_rd_data[6:5];
                duplex_q <= mdio_rd_data[3];
                state_q  <= S_POLL_BM;
              end
              S_POLL_BM: begin
                link_q  <= mdio_rd_data[2];
                lc_q    <= mdio_rd_data[2] ^ link_q;
                sv_q    <= 1'b1;
                gap_q   <= '0;
                state_q <= S_GAP;
              end
              default: state_q <= S_ID_RD;
            endcase
            if (pend_d) begin
              state_q   <= S_ID_RD;
              pending_q <= 1'b0;
              done_q    <= 1'b0;
            end
          end
        end
        default: phase_q <= PH_ISSUE;
      endcase
`ifdef PHY_SEQ_WATCHDOG_EN
      // Abandon a hung transaction; the engine finishes on its own and ID_RD waits for ready.
      if (phase_q != PH_ISSUE && wd_q == WD_W'(TIMEOUT - 1)) begin
        err_q    <= 1'b1;
        done_q   <= 1'b0;
        phase_q  <= PH_ISSUE;
        state_q  <= S_GAP;
        gap_q    <= '0;
        reinit_q <= 1'b1;
      end
`endif
    end
  end

  assign tbl_sel         = sel_q;
  assign tbl_idx         = idx_q;
  assign mdio_addr       = addr_q;
  assign mdio_wr_data    = wdat_q;
  assign mdio_rd_request = rd_q;
  assign mdio_wr_request = wr_q;
  assign speed           = speed_q;
  assign duplex          = duplex_q;
  assign link            = link_q;
  assign phy_variant     = var_q;
  assign cfg_done        = done_q;
  assign status_valid    = sv_q;
  assign link_change     = lc_q;
`ifdef PHY_SEQ_WATCHDOG_EN
  assign err             = err_q;
`else
  assign err             = 1'b0;
`endif

endmodule

// File: doc/phy_seq_cfg.md
# phy_seq_cfg

Parametrised, table-driven successor to the PHY startup/status sequencer. It identifies the attached PHY variant by reading an ID register, then writes a variant-specific configuration table through a Clause-22 MDIO engine. After that it polls link, speed and duplex continuously. It sits between the Ethernet MAC control logic and the MDIO engine, in the 2.5 MHz MDIO clock domain. The write tables live outside the block and are read through a small lookup port.

## Interface
Parameters:
- IDX_W, 3: table index width.
- DEPTH_A, 4: number of writes when the ID matches (variant A); range 1..2^IDX_W.
- DEPTH_B, 2: number of writes otherwise (variant B); range 1..2^IDX_W.
- ID_REG, 5'h03: register read for identification.
- ID_MASK, 16'h0030: mask applied to the ID read data.
- ID_MATCH, 16'h0010: the ID matches (variant A) when (rd_data & ID_MASK) == ID_MATCH.
- STATUS_REG, 5'h1f: vendor status register; speed is bits [6:5], duplex is bit [3].
- POLL_GAP, 250: idle cycles between poll rounds (100 µs at 2.5 MHz).
- TIMEOUT, 1024: watchdog limit in cycles (used only with PHY_SEQ_WATCHDOG_EN).

Ports:
- clock, in, 1: 2.5 MHz MDIO clock.
- reset_n, in, 1: synchronous, active-low reset.
- init_request, in, 1: pulse or level; requests re-identification and reconfiguration.
- tbl_sel, out, 1: 0 selects table A, 1 selects table B.
- tbl_idx, out, IDX_W: current table entry.
- tbl_addr, in, 5: register address for the entry at {tbl_sel, tbl_idx}; combinational.
- tbl_data, in, 16: write value for the entry at {tbl_sel, tbl_idx}; combinational.
- mdio_addr, out, 5: register address to the MDIO engine.
- mdio_wr_data, out, 16: write data to the MDIO engine.
- mdio_rd_request, out, 1: one-cycle read strobe.
- mdio_wr_request, out, 1: one-cycle write strobe.
- mdio_ready, in, 1: engine idle; a rising edge means the transaction is complete.
- mdio_rd_data, in, 16: read data; valid while mdio_ready is high after a read.
- speed, out, 2: PHY speed code.
- duplex, out, 1: 1 = full duplex.
- link, out, 1: BMSR (reg 0x01) bit 2.
- phy_variant, out, 1: 1 = variant B (ID did not match).
- cfg_done, out, 1: table writes have completed since the last identification.
- status_valid, out, 1: one-cycle pulse after each complete poll round.
- link_change, out, 1: one-cycle pulse when link toggles.
- err, out, 1: sticky watchdog flag; cleared by reset only.

## Operation
States:
- ID_RD: issue a read of ID_REG. On completion:
  - phy_variant = !(match); tbl_sel = phy_variant; tbl_idx = 0; cfg_done = 0.
  - go to WR.
- WR: issue a write with the tbl_addr/tbl_data sampled in the issue cycle.
  - On completion, if tbl_idx == depth-1 (depth = DEPTH_A or DEPTH_B): set cfg_done and go to POLL_ST.
  - Otherwise increment tbl_idx and stay in WR.
- POLL_ST: read STATUS_REG; latch speed and duplex on completion.
- POLL_BM: read 0x01; latch link and pulse status_valid on completion.
  - Pulse link_change if the new link value differs from the previous one.
  - Go to GAP.
- GAP: count POLL_GAP cycles, then go to POLL_ST.

Every issue state first waits for mdio_ready=1, then asserts its request for exactly one cycle. It then waits for mdio_ready to go low (BUSY) and then high again (DONE).

init_request:
- Latched into a pending flag at any time.
- Acted on only at a transaction boundary (DONE) or in GAP. The sequencer then goes to ID_RD, clears the flag and sets cfg_done=0.
- An init_request that arrives during a table write is serviced after that write; the table restarts from index 0.
- Polling continues to update speed, duplex and link unaffected by the re-init until ID_RD begins.

Arithmetic: tbl_idx is IDX_W bits wide and never exceeds depth-1, so it has no wrap-around. The GAP counter is sized as $clog2(POLL_GAP+1) bits.

## Timing
- Reset values: speed=2'b00, duplex=0, link=0, phy_variant=0, cfg_done=0, status_valid=0, link_change=0, err=0, strobes=0, tbl_idx=0, tbl_sel=0, mdio_addr=0, mdio_wr_data=0, state=ID_RD, pending=0.
- reset_n low mid-transaction: the strobe is dropped on the next edge; the engine is left to finish on its own. After release, ID_RD waits for mdio_ready=1 before issuing.
- mdio_addr and mdio_wr_data are registered in the request cycle and held stable until DONE.
- Result registers update on the edge that samples mdio_ready rising (DONE). status_valid and link_change are high in the following cycle.
- Back-to-back table writes: the next request is issued at the earliest one cycle after DONE.
- If the engine raises ready in the same cycle a request is issued, no new request is issued until the BUSY phase has been observed.

## Configuration
- PHY_SEQ_WATCHDOG_EN defined:
  - A counter clears on each request and counts while in BUSY or DONE wait.
  - When it reaches TIMEOUT: set err, drop the transaction, assert cfg_done=0 and go to GAP. After GAP, go to ID_RD (full re-identification).
- PHY_SEQ_WATCHDOG_EN undefined:
  - The sequencer waits indefinitely.
  - err is tied to 0 and no counter logic is generated.

## Test plan
- ID read returns 16'h0010 (match): phy_variant=0. Exactly 4 writes follow, using tbl_idx 0..3 with the table A addr/data. Then cfg_done=1, followed by polling of 0x1f and then 0x01.
- ID read returns 16'h0020: phy_variant=1. Exactly 2 writes from table B, then cfg_done=1.
- Status reads of 16'h0048 and then BMSR 16'h0004: speed=2'b10, duplex=1, link=1. One status_valid pulse and one link_change pulse; the gap to the next request is POLL_GAP.
- init_request pulsed during table write 2: that write completes, then the ID_RD request is issued, then the writes restart at tbl_idx=0.
- With PHY_SEQ_WATCHDOG_EN, the engine holds ready low for 1100 cycles: err=1 at cycle TIMEOUT after the request. Then GAP, then an ID_RD retry.
- reset_n low for 1 cycle during BUSY: all outputs take their reset values on the next edge. After ready rises, the first request is a read of 5'h03.
